store_write_buffer: RTL and testbench

//  Posted-write buffer between the multicycle CPU's data-memory port and Memoria.

---
 rtl/store_write_buffer_if.sv | 29 ++
 rtl/store_write_buffer.sv | 164 ++++++++++++++++
 tb/tb_store_write_buffer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// CPU data-port and Memoria signal bundle for the posted-write buffer.
// slave = buffer side, master = CPU/memory side (the bench drives through master).
// Store handshake: a store transfers on a posedge where cpu_wr_valid and cpu_wr_ready are both high;
// valid may rise at any time, and ready depends only on buffer occupancy, never on valid.
interface store_write_buffer_if;
   logic        cpu_wr_valid;
   logic        cpu_wr_ready;
   logic [31:0] cpu_wr_addr;
   logic [31:0] cpu_wr_data;
   logic        cpu_rd_req;
   logic [31:0] cpu_rd_addr;
   logic        cpu_rd_done;
   logic [31:0] cpu_rd_data;
   logic        wbuf_empty;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr, mem_rdata,
      output cpu_wr_ready, cpu_rd_done, cpu_rd_data, wbuf_empty, mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr, mem_rdata,
      input  cpu_wr_ready, cpu_rd_done, cpu_rd_data, wbuf_empty, mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the CPU data port and Memoria; reads keep program order.
// Optional macro WBUF_FORWARD_EN: forward loads from buffered stores and let misses bypass the FIFO.
module store_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   store_write_buffer_if.slave    bus,
   output logic [1:0]             dbg_state_o,
   output logic [$clog2(DEPTH):0] dbg_count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(MEM_RD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RD_WAIT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               rd_done_q, rd_done_d;
   logic [31:0]        rd_data_q, rd_data_d;

   logic [31:0]        addr_q [DEPTH];
   logic [31:0]        data_q [DEPTH];

   logic               push;
   logic               pop;
   logic               rd_pending;
   logic               fwd_hit;
   logic [31:0]        fwd_data;
   logic               bypass_ok;

   assign bus.cpu_wr_ready = (count_q != CNT_W'(DEPTH));
   assign push             = bus.cpu_wr_valid & bus.cpu_wr_ready;
   assign pop              = (state_q == WRITE);
   // The request stays high through the done cycle; do not serve it twice.
   assign rd_pending       = bus.cpu_rd_req & ~rd_done_q;

   // Entry storage needs no reset: only slots inside the count window are ever read.
   always_ff @(posedge Clk) begin
      if (push) begin
         addr_q[tail_q] <= bus.cpu_wr_addr;
         data_q[tail_q] <= bus.cpu_wr_data;
      end
   end

`ifdef WBUF_FORWARD_EN
   // Scan oldest to newest so the newest matching entry is the one that sticks.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) &&
             (addr_q[head_q + PTR_W'(i)][31:2] == bus.cpu_rd_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head_q + PTR_W'(i)];
         end
      end
   end
   assign bypass_ok = 1'b1;
`else
   assign fwd_hit   = 1'b0;
   assign fwd_data  = '0;
   assign bypass_ok = 1'b0;
`endif

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      rd_done_d = 1'b0;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (rd_pending) begin
               if (fwd_hit) begin
                  rd_done_d = 1'b1;
                  rd_data_d = fwd_data;
               end else if ((count_q == '0) || bypass_ok) begin
                  state_d = RD_WAIT;
                  lat_d   = LAT_W'(MEM_RD_LAT);
               end else begin
                  state_d = WRITE;
               end
            end else if (count_q != '0) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         RD_WAIT: begin
            lat_d = lat_q - LAT_W'(1);
            // Counter reaching zero this cycle means mem_rdata is valid now.
            if (lat_q == LAT_W'(1)) begin
               rd_done_d = 1'b1;
               rd_data_d = bus.mem_rdata;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         lat_q     <= '0;
         rd_done_q <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         lat_q     <= lat_d;
         rd_done_q <= rd_done_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.mem_wr      = (state_q == WRITE);
   assign bus.mem_addr    = (state_q == WRITE) ? addr_q[head_q] : bus.cpu_rd_addr;
   assign bus.mem_wdata   = data_q[head_q];
   assign bus.cpu_rd_done = rd_done_q;
   assign bus.cpu_rd_data = rd_data_q;
   assign bus.wbuf_empty  = (count_q == '0);
   assign dbg_state_o     = state_q;
   assign dbg_count_o     = count_q;

   a_count_bound: assert property (@(posedge Clk) disable iff (!Reset)
      count_q <= CNT_W'(DEPTH));
   a_no_empty_pop: assert property (@(posedge Clk) disable iff (!Reset)
      (state_q == WRITE) |-> (count_q != '0));
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: Memoria model, write/read scoreboards, read-latency table.
// Expectations follow WBUF_FORWARD_EN the same way the design does.
module tb_store_write_buffer;
   localparam int DEPTH      = 4;
   localparam int MEM_RD_LAT = 1;
   localparam int CNT_W      = $clog2(DEPTH) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_write_buffer_if bus();
   logic [1:0]       dbg_state;
   logic [CNT_W-1:0] dbg_count;

   store_write_buffer #(.DEPTH(DEPTH), .MEM_RD_LAT(MEM_RD_LAT)) dut (
      .Clk         (clk),
      .Reset       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_count_o (dbg_count)
   );

   int total = 0;
   int bad   = 0;

   logic [63:0] wr_exp_q[$];
   logic [31:0] rd_exp_q[$];
   int          wr_seen = 0;
   bit          saw_full = 0;
   bit          saw_rdwait = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memoria model: registered read pipeline of MEM_RD_LAT stages, write on posedge.
   logic [31:0] mem [0:1023];
   logic [31:0] rd_pipe [MEM_RD_LAT];
   logic        bd_we = 1'b0;
   logic [31:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   always @(posedge clk) begin
      if (bus.mem_wr) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      if (bd_we) mem[bd_addr[11:2]] <= bd_data;
      rd_pipe[0] <= mem[bus.mem_addr[11:2]];
      for (int i = 1; i < MEM_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[MEM_RD_LAT-1];

   // Monitors sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus.cpu_wr_ready) saw_full = 1'b1;
         if (dbg_state == 2'd2) saw_rdwait = 1'b1;
         if (bus.mem_wr) begin
            wr_seen++;
            if (wr_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_mem_write actual=%h required=none",
                        {bus.mem_addr, bus.mem_wdata});
            end else begin
               chk("mem_write", {bus.mem_addr, bus.mem_wdata}, wr_exp_q.pop_front());
            end
         end
         if (bus.cpu_rd_done) begin
            if (rd_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rd_done actual=%h required=none", bus.cpu_rd_data);
            end else begin
               chk("rd_data", {32'h0, bus.cpu_rd_data}, {32'h0, rd_exp_q.pop_front()});
            end
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_addr  = a;
      bus.cpu_wr_data  = d;
      while (!bus.cpu_wr_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("push_timeout", 64'(n), 64'(0));
      wr_exp_q.push_back({a, d});
      @(posedge clk); #1;
      bus.cpu_wr_valid = 1'b0;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      bd_we = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                          input int exp_lat);
      int lat = 0;
      rd_exp_q.push_back(exp);
      bus.cpu_rd_req  = 1'b1;
      bus.cpu_rd_addr = a;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.cpu_rd_done && lat < 200);
      if (lat >= 200) chk({name, "_timeout"}, 64'(lat), 64'(0));
      else if (exp_lat > 0) chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      bus.cpu_rd_req = 1'b0;
   endtask

   task automatic wait_drained(input string name);
      int n = 0;
      while (!(bus.wbuf_empty && dbg_state == 2'd0 && !bus.cpu_rd_done) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) chk({name, "_drain_timeout"}, 64'(n), 64'(0));
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic [31:0] rd_addr;
      logic [31:0] pre_data;
      logic [31:0] exp_data;
      int          exp_lat;
   } rd_vec_t;

   rd_vec_t vecs[5];

   initial begin
      int hit_lat;
      int miss_lat;
      int snap;
`ifdef WBUF_FORWARD_EN
      hit_lat  = 1;
      miss_lat = MEM_RD_LAT + 1;
`else
      hit_lat  = 2 + MEM_RD_LAT + 1;
      miss_lat = 2 + MEM_RD_LAT + 1;
`endif
      vecs[0] = '{32'h0000_0500, 32'h0000_5555, 32'h0000_0500, 32'h1111_0500, 32'h0000_5555, hit_lat};
      vecs[1] = '{32'h0000_0300, 32'h0000_3333, 32'h0000_0400, 32'h0000_1234, 32'h0000_1234, miss_lat};
      vecs[2] = '{32'h0000_0600, 32'h0000_6666, 32'h0000_0604, 32'hCAFE_0604, 32'hCAFE_0604, miss_lat};
      vecs[3] = '{32'h0000_0700, 32'h0000_7777, 32'h0000_0700, 32'h2222_0700, 32'h0000_7777, hit_lat};
      vecs[4] = '{32'h0000_0010, 32'h0000_0001, 32'h0000_0014, 32'hBADC_0DE0, 32'hBADC_0DE0, miss_lat};

      bus.cpu_wr_valid = 1'b0;
      bus.cpu_wr_addr  = '0;
      bus.cpu_wr_data  = '0;
      bus.cpu_rd_req   = 1'b0;
      bus.cpu_rd_addr  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_ready", 64'(bus.cpu_wr_ready), 64'(1));
      chk("rst_empty",    64'(bus.wbuf_empty),   64'(1));
      chk("rst_mem_wr",   64'(bus.mem_wr),       64'(0));
      chk("rst_rd_done",  64'(bus.cpu_rd_done),  64'(0));
      chk("rst_rd_data",  64'(bus.cpu_rd_data),  64'(0));
      chk("rst_state",    64'(dbg_state),        64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Three stores, no reads: drained in order, buffer empty afterwards.
      snap = wr_seen;
      push(32'h100, 32'hA);
      push(32'h104, 32'hB);
      push(32'h108, 32'hC);
      wait_drained("t1");
      chk("t1_writes", 64'(wr_seen - snap), 64'(3));
      chk("t1_empty",  64'(bus.wbuf_empty), 64'(1));

      // Read latency / source table: one buffered store, then a read next cycle.
      for (int i = 0; i < 5; i++) begin
         wait_drained($sformatf("vec%0d", i));
         preload(vecs[i].rd_addr, vecs[i].pre_data);
         push(vecs[i].wr_addr, vecs[i].wr_data);
         do_read($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].exp_data, vecs[i].exp_lat);
      end
      wait_drained("vecs");
      chk("vecs_wr_q_empty", 64'(wr_exp_q.size()), 64'(0));

      // Same address stored twice; the read must see the newer value.
      preload(32'h200, 32'h0);
      push(32'h200, 32'hDEAD);
      push(32'h200, 32'hBEEF);
      saw_rdwait = 1'b0;
      do_read("t3", 32'h200, 32'hBEEF, 0);
`ifdef WBUF_FORWARD_EN
      chk("t3_no_mem_read", 64'(saw_rdwait), 64'(0));
`else
      chk("t3_mem_read", 64'(saw_rdwait), 64'(1));
`endif
      wait_drained("t3");
      chk("t3_wr_q_empty", 64'(wr_exp_q.size()), 64'(0));

      // Eight back-to-back stores overrun the drain rate and fill the FIFO.
      saw_full = 1'b0;
      snap = wr_seen;
      for (int i = 0; i < 8; i++) push(32'h800 + 32'(i*4), 32'h8000 + 32'(i));
      wait_drained("t2");
      chk("t2_saw_full", 64'(saw_full), 64'(1));
      chk("t2_writes",   64'(wr_seen - snap), 64'(8));
      chk("t2_wr_q_empty", 64'(wr_exp_q.size()), 64'(0));

      // Push during a WRITE cycle with two entries: occupancy stays at two.
      push(32'h900, 32'h91);
      push(32'h904, 32'h92);
      chk("t6_state_write", 64'(dbg_state), 64'(1));
      chk("t6_count_before", 64'(dbg_count), 64'(2));
      push(32'h908, 32'h93);
      chk("t6_count_after", 64'(dbg_count), 64'(2));
      wait_drained("t6");
      chk("t6_wr_q_empty", 64'(wr_exp_q.size()), 64'(0));

      // Reset asserted mid-WRITE discards the remaining stores.
      push(32'hA00, 32'hA1);
      push(32'hA04, 32'hA2);
      chk("t5_state_write", 64'(dbg_state), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("t5_mem_wr_low", 64'(bus.mem_wr),       64'(0));
      chk("t5_empty",      64'(bus.wbuf_empty),   64'(1));
      chk("t5_wr_ready",   64'(bus.cpu_wr_ready), 64'(1));
      chk("t5_rd_done",    64'(bus.cpu_rd_done),  64'(0));
      wr_exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      snap = wr_seen;
      repeat (10) @(posedge clk);
      #1;
      chk("t5_no_writes_after", 64'(wr_seen - snap), 64'(0));
      chk("t5_state_idle", 64'(dbg_state), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
